// File: rtl/isa_pkg.sv
// Shared ISA definitions for the instruction sequencer: opcodes, field positions, FSM states.
package isa_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_JMP  = 4'h3;
    localparam logic [3:0] OP_UP   = 4'h4;
    localparam logic [3:0] OP_JZ   = 4'h5;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 10;
    localparam int RS_MSB  = 9;
    localparam int RS_LSB  = 8;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_DECODE = 2'd1,
        S_EXEC   = 2'd2,
        S_HALT   = 2'd3
    } state_t;

    // Opcodes 6..E are undefined; they execute as NOP but raise the sticky illegal flag.
    function automatic logic is_illegal(input logic [3:0] op);
        return (op >= 4'h6) && (op <= 4'hE);
    endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// Bus between the sequencer, the instruction ROM and the 4x16 register file.
interface instr_sequencer_if #(
    parameter int PC_W = 8
);
    logic [PC_W-1:0] imem_addr;
    logic [15:0]     imem_data;
    logic [1:0]      rs;
    logic [1:0]      rd;
    logic [15:0]     result;
    logic            wr_en;
    logic [15:0]     b;
    logic [15:0]     r0;
    logic [15:0]     r1;
    logic [15:0]     r2;
    logic [15:0]     r3;

    modport master (
        output imem_addr, rs, rd, result, wr_en,
        input  imem_data, b, r0, r1, r2, r3
    );

    modport slave (
        input  imem_addr, rs, rd, result, wr_en,
        output imem_data, b, r0, r1, r2, r3
    );
endinterface

// File: rtl/instr_sequencer_alu.sv
// Combinational execute unit: computes write-back value, carry, zero and write-enable per opcode.
module seq_alu
    import isa_pkg::*;
(
    input  logic [3:0]  opcode,
    input  logic [15:0] rd_val,
    input  logic [15:0] b,
    input  logic [7:0]  imm,
    output logic [15:0] result,
    output logic        carry,
    output logic        zero,
    output logic        writes
);
    logic [16:0] sum;

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        result = '0;
        carry  = 1'b0;
        writes = 1'b0;
        sum    = {1'b0, rd_val} + {1'b0, b};
        case (opcode)
            OP_NOP: ;
            OP_LDI: begin
                result = {8'h00, imm};
                writes = 1'b1;
            end
            OP_ADD: begin
                result = sum[15:0];
                carry  = sum[16];
                writes = 1'b1;
            end
            OP_UP: begin
                result = {imm, rd_val[7:0]};
                writes = 1'b1;
            end
            default: ;
        endcase
        zero = (result == 16'h0000);
    end

endmodule

// File: rtl/instr_sequencer.sv
// Three-cycle fetch/decode/execute controller driving the 4x16 register file.
module instr_sequencer
    import isa_pkg::*;
#(
    parameter int              PC_W     = 8,
    parameter int              DATA_W   = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    instr_sequencer_if.master  bus,
    output logic [PC_W-1:0]    pc,
    output logic               zero_flag,
    output logic               carry_flag,
    output logic               illegal,
    output logic               halted,
    output logic [15:0]        retired
);
    state_t            state;
    logic [DATA_W-1:0] ir;

    logic [3:0]  opcode;
    logic [7:0]  imm;
    logic [15:0] rd_val;
    logic [15:0] alu_result;
    logic        alu_carry;
    logic        alu_zero;
    logic        alu_writes;
    logic [PC_W-1:0] pc_next;
    logic [PC_W-1:0] pc_target;

    assign opcode    = ir[OPC_MSB:OPC_LSB];
    assign imm       = ir[IMM_MSB:IMM_LSB];
    assign pc_target = PC_W'(imm);

    always_comb begin
        rd_val = bus.r0;
        case (ir[RD_MSB:RD_LSB])
            2'd1:    rd_val = bus.r1;
            2'd2:    rd_val = bus.r2;
            2'd3:    rd_val = bus.r3;
            default: rd_val = bus.r0;
        endcase
    end

    seq_alu u_alu (
        .opcode (opcode),
        .rd_val (rd_val),
        .b      (bus.b),
        .imm    (imm),
        .result (alu_result),
        .carry  (alu_carry),
        .zero   (alu_zero),
        .writes (alu_writes)
    );

    always_comb begin
        pc_next = pc + 1'b1;
        case (opcode)
            OP_JMP:  pc_next = pc_target;
            OP_JZ:   pc_next = zero_flag ? pc_target : pc + 1'b1;
            OP_HALT: pc_next = pc;
            default: pc_next = pc + 1'b1;
        endcase
    end

    assign bus.imem_addr = pc;
    assign bus.rs        = ir[RS_MSB:RS_LSB];
    assign bus.rd        = ir[RD_MSB:RD_LSB];
    assign bus.result    = alu_result;
    // NOTE: reset is synchronous, so the strobe is masked by rst directly to suppress a write in the reset cycle.
    assign bus.wr_en     = (state == S_EXEC) && alu_writes && !rst;

    // NOTE: all state updates use non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_FETCH;
            pc         <= RESET_PC;
            ir         <= '0;
            zero_flag  <= 1'b0;
            carry_flag <= 1'b0;
            illegal    <= 1'b0;
            halted     <= 1'b0;
            retired    <= '0;
        end else begin
            case (state)
                S_FETCH: state <= S_DECODE;
                S_DECODE: begin
                    ir    <= bus.imem_data;
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    pc      <= pc_next;
                    retired <= retired + 1'b1;
                    if (alu_writes)         zero_flag  <= alu_zero;
                    if (opcode == OP_ADD)   carry_flag <= alu_carry;
                    if (is_illegal(opcode)) illegal    <= 1'b1;
                    if (opcode == OP_HALT) begin
                        state  <= S_HALT;
                        halted <= 1'b1;
                    end else begin
                        state <= S_FETCH;
                    end
                end
                S_HALT:  state <= S_HALT;
                default: state <= S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer with a behavioural ROM and 4x16 register file around it.
module tb_instr_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clear_regs = 1'b1;
    logic [7:0]  pc;
    logic        zero_flag, carry_flag, illegal, halted;
    logic [15:0] retired;

    logic [15:0] rom  [256];
    logic [15:0] regs [4];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    instr_sequencer_if #(.PC_W(8)) bus();

    instr_sequencer #(.PC_W(8), .DATA_W(16), .RESET_PC(8'h00)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .pc         (pc),
        .zero_flag  (zero_flag),
        .carry_flag (carry_flag),
        .illegal    (illegal),
        .halted     (halted),
        .retired    (retired)
    );

    always #5 clk = ~clk;

    always @(posedge clk) bus.imem_data <= rom[bus.imem_addr];

    always @(posedge clk) begin
        if (clear_regs) begin
            for (int i = 0; i < 4; i++) regs[i] <= 16'h0000;
        end else if (bus.wr_en) begin
            regs[bus.rd] <= bus.result;
        end
    end

    assign bus.b  = regs[bus.rs];
    assign bus.r0 = regs[0];
    assign bus.r1 = regs[1];
    assign bus.r2 = regs[2];
    assign bus.r3 = regs[3];

    function automatic logic [15:0] enc(input logic [3:0] op, input logic [1:0] rd,
                                        input logic [1:0] rs, input logic [7:0] imm);
        return {op, rd, rs, imm};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) step();
    endtask

    // Leaves the bench in cycle 1 (first cycle after rst deasserts) with ROM and registers cleared.
    task automatic do_reset();
        rst = 1'b1;
        clear_regs = 1'b1;
        for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        clear_regs = 1'b0;
        cyc = 1;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (pc !== 8'h00) begin bad++; $display("FAIL reset_pc got=%h want=%h", pc, 8'h00); end
        total++; if ({zero_flag, carry_flag, illegal, halted} !== 4'b0000) begin bad++; $display("FAIL reset_flags got=%b want=%b", {zero_flag, carry_flag, illegal, halted}, 4'b0000); end
        total++; if (retired !== 16'h0000) begin bad++; $display("FAIL reset_retired got=%h want=%h", retired, 16'h0000); end
        total++; if (bus.wr_en !== 1'b0) begin bad++; $display("FAIL reset_wr_en got=%b want=0", bus.wr_en); end
        total++; if ({bus.rs, bus.rd, bus.result} !== 20'h0) begin bad++; $display("FAIL reset_rs_rd_result got=%h want=0", {bus.rs, bus.rd, bus.result}); end
        total++; if (bus.imem_addr !== 8'h00) begin bad++; $display("FAIL reset_imem_addr got=%h want=00", bus.imem_addr); end
    endtask

    task automatic test_add_halt();
        logic exp_wr;
        do_reset();
        rom[0] = enc(4'h1, 2'd0, 2'd0, 8'h05);
        rom[1] = enc(4'h1, 2'd1, 2'd0, 8'h03);
        rom[2] = enc(4'h2, 2'd0, 2'd1, 8'h00);
        rom[3] = 16'hF000;
        for (int c = 1; c <= 13; c++) begin
            run_to(c);
            exp_wr = (c == 3) || (c == 6) || (c == 9);
            total++; if (bus.wr_en !== exp_wr) begin bad++; $display("FAIL t1_wr_en_cycle%0d got=%b want=%b", c, bus.wr_en, exp_wr); end
            total++; if (halted !== (c >= 13)) begin bad++; $display("FAIL t1_halted_cycle%0d got=%b want=%b", c, halted, (c >= 13)); end
        end
        total++; if (retired !== 16'd4) begin bad++; $display("FAIL t1_retired_at13 got=%0d want=4", retired); end
        run_to(25);
        total++; if (regs[0] !== 16'h0008) begin bad++; $display("FAIL t1_r0 got=%h want=0008", regs[0]); end
        total++; if (regs[1] !== 16'h0003) begin bad++; $display("FAIL t1_r1 got=%h want=0003", regs[1]); end
        total++; if ({zero_flag, carry_flag} !== 2'b00) begin bad++; $display("FAIL t1_flags got=%b want=00", {zero_flag, carry_flag}); end
        total++; if (retired !== 16'd4) begin bad++; $display("FAIL t1_retired_hold got=%0d want=4", retired); end
        total++; if (pc !== 8'h03) begin bad++; $display("FAIL t1_pc_halt got=%h want=03", pc); end
        total++; if (bus.wr_en !== 1'b0) begin bad++; $display("FAIL t1_halt_wr_en got=%b want=0", bus.wr_en); end
    endtask

    task automatic test_up_carry();
        do_reset();
        rom[0] = enc(4'h1, 2'd2, 2'd0, 8'hFF);
        rom[1] = enc(4'h4, 2'd2, 2'd0, 8'hFF);
        rom[2] = enc(4'h4, 2'd3, 2'd0, 8'h80);
        rom[3] = enc(4'h2, 2'd2, 2'd3, 8'h00);
        run_to(7);
        total++; if (regs[2] !== 16'hFFFF) begin bad++; $display("FAIL t2_up_r2 got=%h want=FFFF", regs[2]); end
        run_to(10);
        total++; if (regs[3] !== 16'h8000) begin bad++; $display("FAIL t2_up_r3 got=%h want=8000", regs[3]); end
        total++; if (zero_flag !== 1'b0) begin bad++; $display("FAIL t2_zero_after_up got=%b want=0", zero_flag); end
        run_to(13);
        total++; if (regs[2] !== 16'h7FFF) begin bad++; $display("FAIL t2_add_r2 got=%h want=7FFF", regs[2]); end
        total++; if (carry_flag !== 1'b1) begin bad++; $display("FAIL t2_carry got=%b want=1", carry_flag); end
        total++; if (zero_flag !== 1'b0) begin bad++; $display("FAIL t2_zero got=%b want=0", zero_flag); end
        total++; if (pc !== 8'h04) begin bad++; $display("FAIL t2_pc got=%h want=04", pc); end
    endtask

    task automatic test_jz();
        do_reset();
        rom[8'h00] = enc(4'h1, 2'd0, 2'd0, 8'h00);
        rom[8'h01] = enc(4'h5, 2'd0, 2'd0, 8'h10);
        rom[8'h10] = enc(4'h1, 2'd1, 2'd0, 8'h01);
        rom[8'h11] = enc(4'h5, 2'd0, 2'd0, 8'h20);
        run_to(4);
        total++; if (zero_flag !== 1'b1) begin bad++; $display("FAIL t3_zero_set got=%b want=1", zero_flag); end
        run_to(7);
        total++; if (pc !== 8'h10) begin bad++; $display("FAIL t3_jz_taken got=%h want=10", pc); end
        run_to(13);
        total++; if (pc !== 8'h12) begin bad++; $display("FAIL t3_jz_not_taken got=%h want=12", pc); end
        total++; if (regs[1] !== 16'h0001) begin bad++; $display("FAIL t3_r1 got=%h want=0001", regs[1]); end
        total++; if (zero_flag !== 1'b0) begin bad++; $display("FAIL t3_zero_clear got=%b want=0", zero_flag); end
    endtask

    task automatic test_jmp_wrap();
        logic [7:0] exp_pc;
        do_reset();
        rom[8'h00] = enc(4'h3, 2'd0, 2'd0, 8'hFF);
        rom[8'hFF] = 16'h0000;
        for (int k = 1; k <= 4; k++) begin
            run_to(3 * k + 1);
            exp_pc = (k % 2 == 1) ? 8'hFF : 8'h00;
            total++; if (pc !== exp_pc) begin bad++; $display("FAIL t4_pc_k%0d got=%h want=%h", k, pc, exp_pc); end
            total++; if (retired !== 16'(k)) begin bad++; $display("FAIL t4_retired_k%0d got=%0d want=%0d", k, retired, k); end
        end
        run_to(15);
        total++; if (retired !== 16'd4) begin bad++; $display("FAIL t4_retired_mid got=%0d want=4", retired); end
    endtask

    task automatic test_illegal();
        do_reset();
        rom[0] = enc(4'h1, 2'd0, 2'd0, 8'h00);
        rom[1] = 16'h7523;
        rom[2] = 16'hF000;
        run_to(4);
        total++; if (illegal !== 1'b0) begin bad++; $display("FAIL t5_illegal_early got=%b want=0", illegal); end
        run_to(6);
        total++; if (bus.wr_en !== 1'b0) begin bad++; $display("FAIL t5_no_wr_en got=%b want=0", bus.wr_en); end
        run_to(7);
        total++; if (illegal !== 1'b1) begin bad++; $display("FAIL t5_illegal_set got=%b want=1", illegal); end
        total++; if (pc !== 8'h02) begin bad++; $display("FAIL t5_pc got=%h want=02", pc); end
        total++; if ({zero_flag, carry_flag} !== 2'b10) begin bad++; $display("FAIL t5_flags_hold got=%b want=10", {zero_flag, carry_flag}); end
        total++; if (regs[1] !== 16'h0000) begin bad++; $display("FAIL t5_r1_untouched got=%h want=0000", regs[1]); end
        run_to(12);
        total++; if ({illegal, halted} !== 2'b11) begin bad++; $display("FAIL t5_sticky got=%b want=11", {illegal, halted}); end
    endtask

    task automatic test_reset_mid_exec();
        do_reset();
        rom[0] = enc(4'h1, 2'd0, 2'd0, 8'h05);
        rom[1] = enc(4'h1, 2'd1, 2'd0, 8'h03);
        rom[2] = enc(4'h2, 2'd0, 2'd1, 8'h00);
        rom[3] = 16'hF000;
        run_to(9);
        total++; if (bus.wr_en !== 1'b1) begin bad++; $display("FAIL t6_add_exec_wr_en got=%b want=1", bus.wr_en); end
        rst = 1'b1;
        #1;
        total++; if (bus.wr_en !== 1'b0) begin bad++; $display("FAIL t6_wr_en_in_reset got=%b want=0", bus.wr_en); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 1;
        total++; if (regs[0] !== 16'h0005) begin bad++; $display("FAIL t6_no_write got=%h want=0005", regs[0]); end
        total++; if (pc !== 8'h00) begin bad++; $display("FAIL t6_pc got=%h want=00", pc); end
        total++; if (retired !== 16'h0000) begin bad++; $display("FAIL t6_retired got=%0d want=0", retired); end
        total++; if ({zero_flag, carry_flag, illegal, halted} !== 4'b0000) begin bad++; $display("FAIL t6_flags got=%b want=0000", {zero_flag, carry_flag, illegal, halted}); end
        total++; if (bus.wr_en !== 1'b0) begin bad++; $display("FAIL t6_fetch_wr_en got=%b want=0", bus.wr_en); end
        run_to(10);
        total++; if (regs[0] !== 16'h0008) begin bad++; $display("FAIL t6_restart_r0 got=%h want=0008", regs[0]); end
        total++; if (retired !== 16'd3) begin bad++; $display("FAIL t6_restart_retired got=%0d want=3", retired); end
        total++; if (pc !== 8'h03) begin bad++; $display("FAIL t6_restart_pc got=%h want=03", pc); end
    endtask

    initial begin
        test_reset();
        test_add_halt();
        test_up_carry();
        test_jz();
        test_jmp_wrap();
        test_illegal();
        test_reset_mid_exec();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
